// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the FSM state enum and a one-hot helper.
package mux_arb_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [C_NUM_REQ-1:0] f_onehot(
        input logic [C_SEL_W-1:0] i_idx
    );
        return 4'b0001 << i_idx;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 1-bit 4:1 data multiplexer.
// i_SEL picks one of i_A..i_D.
module mux_4_1 (
    input  logic       i_A,
    input  logic       i_B,
    input  logic       i_C,
    input  logic       i_D,
    input  logic [1:0] i_SEL,
    output logic       o_Y
);

    // select one of the four inputs
    always_comb begin
        o_Y = i_A;
        unique case (i_SEL)
            2'd0: o_Y = i_A;
            2'd1: o_Y = i_B;
            2'd2: o_Y = i_C;
            2'd3: o_Y = i_D;
            default: o_Y = i_A;
        endcase
    end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker for four requesters.
// Searches from i_PTR upward, wrapping 3->0.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [C_NUM_REQ-1:0] i_REQ,
    input  logic [C_SEL_W-1:0]   i_PTR,
    output logic [C_SEL_W-1:0]   o_IDX,
    output logic                 o_ANY
);

    logic [C_SEL_W-1:0] w_cand;
    logic               w_found;

    // first set request at or after the pointer wins
    always_comb begin
        o_IDX   = i_PTR;
        w_cand  = i_PTR;
        w_found = 1'b0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            w_cand = i_PTR + C_SEL_W'(i);
            if (!w_found && i_REQ[w_cand]) begin
                o_IDX   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign o_ANY = |i_REQ;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 data mux.
// Optional grant hold limit: define MUX_ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int P_DATA_W   = 1,
    parameter int P_HOLD_MAX = 8
) (
    input  logic                            i_CLK,
    input  logic                            i_RST_N,
    input  logic [C_NUM_REQ-1:0]            i_REQ,
    input  logic [C_NUM_REQ*P_DATA_W-1:0]   i_DATA,
    output logic [C_NUM_REQ-1:0]            o_GNT,
    output logic [C_SEL_W-1:0]              o_SEL,
    output logic                            o_BUSY,
    output logic                            o_VALID,
    output logic [P_DATA_W-1:0]             o_DATA,
    output logic                            o_TIMEOUT
);

    if (P_HOLD_MAX < 1 || P_HOLD_MAX > 255) begin : g_bad_hold
        $error("P_HOLD_MAX out of range 1..255");
    end

    state_t                 r_STATE;
    state_t                 w_next;
    logic [C_NUM_REQ-1:0]   r_GNT;
    logic [C_SEL_W-1:0]     r_SEL;
    logic [C_SEL_W-1:0]     r_PTR;
    logic                   r_VALID;
    logic [P_DATA_W-1:0]    r_DATA;
    logic [C_SEL_W-1:0]     w_win;
    logic                   w_any;
    logic                   w_req_sel;
    logic                   w_force;
    logic                   w_start;
    logic [P_DATA_W-1:0]    w_slice;

    rr_pick_4 u_pick (
        .i_REQ (i_REQ),
        .i_PTR (r_PTR),
        .o_IDX (w_win),
        .o_ANY (w_any)
    );

    if (P_DATA_W == 1) begin : g_mux1
        mux_4_1 u_mux (
            .i_A   (i_DATA[0]),
            .i_B   (i_DATA[1]),
            .i_C   (i_DATA[2]),
            .i_D   (i_DATA[3]),
            .i_SEL (r_SEL),
            .o_Y   (w_slice[0])
        );
    end else begin : g_muxw
        assign w_slice = i_DATA[int'(r_SEL)*P_DATA_W +: P_DATA_W];
    end

    assign w_req_sel = i_REQ[r_SEL];
    assign w_start   = (r_STATE == ST_IDLE) && w_any;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [7:0] r_HOLD;
    logic       r_TIMEOUT;

    assign w_force = (r_STATE == ST_BUSY) && w_req_sel &&
                     (r_HOLD == 8'(P_HOLD_MAX));

    // count consecutive busy cycles, saturating at 255
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_HOLD <= 8'd0;
        end else if (w_start) begin
            r_HOLD <= 8'd1;
        end else if (r_STATE == ST_BUSY && r_HOLD != 8'hFF) begin
            r_HOLD <= r_HOLD + 8'd1;
        end
    end

    // flag the idle cycle that follows a forced release
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) r_TIMEOUT <= 1'b0;
        else          r_TIMEOUT <= w_force;
    end

    assign o_TIMEOUT = r_TIMEOUT;
`else
    assign w_force   = 1'b0;
    assign o_TIMEOUT = 1'b0;
`endif

    // next state: grant on any request, release on drop or force
    always_comb begin
        w_next = r_STATE;
        unique case (r_STATE)
            ST_IDLE: if (w_any) w_next = ST_BUSY;
            ST_BUSY: if (!w_req_sel || w_force) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) r_STATE <= ST_IDLE;
        else          r_STATE <= w_next;
    end

    // grant, select and fairness pointer
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_GNT <= '0;
            r_SEL <= '0;
            r_PTR <= '0;
        end else if (w_start) begin
            r_GNT <= f_onehot(w_win);
            r_SEL <= w_win;
            r_PTR <= w_win + 2'd1;
        end else if (r_STATE == ST_BUSY && w_next == ST_IDLE) begin
            r_GNT <= '0;
        end
    end

    // capture granted data one cycle behind the grant
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_VALID <= 1'b0;
            r_DATA  <= '0;
        end else if (r_STATE == ST_BUSY) begin
            r_VALID <= 1'b1;
            r_DATA  <= w_slice;
        end else begin
            r_VALID <= 1'b0;
        end
    end

    assign o_GNT   = r_GNT;
    assign o_SEL   = r_SEL;
    assign o_BUSY  = (r_STATE == ST_BUSY);
    assign o_VALID = r_VALID;
    assign o_DATA  = r_DATA;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (1-bit and 8-bit data builds).
// Hold-limit checks follow MUX_ARB_HOLD_LIMIT_EN.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [3:0]  dat1 = 4'b0;
    logic [31:0] dat8 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    logic [3:0]  gnt, gnt8;
    logic [1:0]  sel, sel8;
    logic        busy, busy8, vld, vld8, tmo, tmo8;
    logic [0:0]  data;
    logic [7:0]  data8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.P_DATA_W(1), .P_HOLD_MAX(4)) u_dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_REQ(req), .i_DATA(dat1),
        .o_GNT(gnt), .o_SEL(sel), .o_BUSY(busy), .o_VALID(vld),
        .o_DATA(data), .o_TIMEOUT(tmo)
    );

    mux_rr_arbiter #(.P_DATA_W(8), .P_HOLD_MAX(4)) u_dut8 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_REQ(req), .i_DATA(dat8),
        .o_GNT(gnt8), .o_SEL(sel8), .o_BUSY(busy8), .o_VALID(vld8),
        .o_DATA(data8), .o_TIMEOUT(tmo8)
    );

    function automatic logic [3:0] oh(input int k);
        return 4'b0001 << k;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0;
        #7;
        n_chk++;
        if ({gnt, sel, busy, vld, data, tmo} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outs got=%b want=0",
                     {gnt, sel, busy, vld, data, tmo});
        end
        n_chk++;
        if (data8 !== 8'h00 || gnt8 !== 4'b0) begin
            n_err++;
            $display("FAIL reset_outs8 got=%h/%b want=00/0000", data8, gnt8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        dat1 = 4'b0100;
        req = 4'b0100;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL single_gnt got=%b/%0d/%b/%b want=0100/2/1/0",
                     gnt, sel, busy, vld);
        end
        @(negedge clk);
        n_chk++;
        if (vld !== 1'b1 || data !== 1'b1 || data8 !== 8'hC2) begin
            n_err++;
            $display("FAIL single_data got=%b/%b/%h want=1/1/c2",
                     vld, data, data8);
        end
        req = 4'b0;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0 || busy !== 1'b0 || vld !== 1'b1) begin
            n_err++;
            $display("FAIL single_drop got=%b/%b/%b want=0000/0/1",
                     gnt, busy, vld);
        end
        @(negedge clk);
        n_chk++;
        if (vld !== 1'b0 || sel !== 2'd2 || data8 !== 8'hC2) begin
            n_err++;
            $display("FAIL single_idle got=%b/%0d/%h want=0/2/c2",
                     vld, sel, data8);
        end
        req = 4'b1001;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_err++;
            $display("FAIL single_ptr got=%b/%0d want=1000/3", gnt, sel);
        end
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        dat1 = 4'b1010;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (gnt !== oh(k % 4) || sel !== 2'(k % 4)) begin
                n_err++;
                $display("FAIL rr_gnt[%0d] got=%b/%0d want=%b/%0d",
                         k, gnt, sel, oh(k % 4), k % 4);
            end
            @(negedge clk);
            n_chk++;
            if (gnt !== oh(k % 4) || vld !== 1'b1 ||
                data[0] !== dat1[k % 4] || data8 !== dat8[(k % 4)*8 +: 8]) begin
                n_err++;
                $display("FAIL rr_hold[%0d] got=%b/%b/%b/%h", k, gnt, vld,
                         data, data8);
            end
            req = 4'b1111 & ~oh(k % 4);
            @(negedge clk);
            n_chk++;
            if (gnt !== 4'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rr_gap[%0d] got=%b/%b want=0000/0", k, gnt, busy);
            end
            req = (k == 4) ? 4'b0 : 4'b1111;
        end
        @(negedge clk);
    endtask

    task automatic test_no_preempt();
        req = 4'b0010;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL np_gnt1 got=%b want=0010", gnt);
        end
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (gnt !== 4'b0010 || sel !== 2'd1) begin
                n_err++;
                $display("FAIL np_keep[%0d] got=%b want=0010", c, gnt);
            end
        end
        req = 4'b1000;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL np_idle got=%b want=0000", gnt);
        end
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_err++;
            $display("FAIL np_gnt3 got=%b/%0d want=1000/3", gnt, sel);
        end
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || vld !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre got=%b/%b want=1/1", busy, vld);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt !== 4'b0 || vld !== 1'b0 || busy !== 1'b0 ||
            sel !== 2'd0 || data8 !== 8'h00) begin
            n_err++;
            $display("FAIL ar_clear got=%b/%b/%b/%0d/%h want=0000/0/0/0/00",
                     gnt, vld, busy, sel, data8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            n_err++;
            $display("FAIL ar_restart got=%b/%0d want=0001/0", gnt, sel);
        end
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_hold();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0011;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++;
            if (gnt !== 4'b0001 || tmo !== 1'b0) begin
                n_err++;
                $display("FAIL hold_gnt[%0d] got=%b/%b want=0001/0", c, gnt, tmo);
            end
        end
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0 || tmo !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_tmo got=%b/%b/%b want=0000/1/0", gnt, tmo, busy);
        end
        @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0010 || tmo !== 1'b0) begin
            n_err++;
            $display("FAIL hold_next got=%b/%b want=0010/0", gnt, tmo);
        end
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_chk++;
            if (gnt !== 4'b0001 || tmo !== 1'b0 || tmo8 !== 1'b0) begin
                n_err++;
                $display("FAIL nohold[%0d] got=%b/%b want=0001/0", c, gnt, tmo);
            end
        end
`endif
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_async_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
